// File: rtl/barrett_final_sub_ctrl.sv
// barrett_final_sub_ctrl: final correction of a Barrett remainder estimate.
// Repeatedly subtracts m while r >= m, using one W-bit slice swept over K chunks per pass.
`default_nettype none

module barrett_final_sub_ctrl #(
  parameter int N       = 1024,
  parameter int W       = 64,
  parameter int MAX_SUB = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N+1:0]   r_in,
  input  logic [N-1:0]   m_in,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result,
  output logic [1:0]     sub_count,
  output logic           err
);

  localparam int K  = (N + 2 + W - 1) / W;
  localparam int KW = K * W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
  localparam logic [1:0]    MAX_CNT  = 2'(MAX_SUB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [KW-1:0]   r_q;
  logic [KW-1:0]   m_q;
  logic [KW-1:0]   d_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [1:0]      cnt;

  logic [W-1:0]    r_chunk;
  logic [W-1:0]    m_chunk;
  logic [W:0]      sum;
  logic [KW-1:0]   d_next;

  // One chunk of R + ~M + carry; the final chunk's carry-out means R >= M.
  always_comb begin
    r_chunk = r_q[idx*W +: W];
    m_chunk = m_q[idx*W +: W];
    sum     = {1'b0, r_chunk} + {1'b0, ~m_chunk} + {{W{1'b0}}, carry};
    d_next  = d_q;
    d_next[idx*W +: W] = sum[W-1:0];
  end

  assign sub_count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r_q    <= '0;
      m_q    <= '0;
      d_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cnt    <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r_q   <= KW'(r_in);
            m_q   <= KW'(m_in);
            d_q   <= '0;
            idx   <= '0;
            carry <= 1'b1;
            cnt   <= 2'd0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= PASS;
          end
        end
        PASS: begin
          d_q   <= d_next;
          carry <= sum[W];
          idx   <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            if (sum[W] && (cnt < MAX_CNT)) begin
              r_q   <= d_next;
              cnt   <= cnt + 2'd1;
              idx   <= '0;
              carry <= 1'b1;
            end else begin
              // Still carrying here means the subtraction budget ran out.
              err    <= sum[W];
              result <= r_q[N-1:0];
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_barrett_final_sub_ctrl.sv
// Self-checking bench: small (N=8,W=4) directed/control cases and random default-size reductions.
`default_nettype none

module tb_barrett_final_sub_ctrl;

  logic clk;
  logic rst_n;

  // Small instance: N=8, W=4, K=3
  logic        s_start;
  logic [9:0]  s_r;
  logic [7:0]  s_m;
  logic        s_busy, s_done, s_err;
  logic [7:0]  s_result;
  logic [1:0]  s_cnt;

  // Default instance: N=1024, W=64, K=17
  logic          l_start;
  logic [1025:0] l_r;
  logic [1023:0] l_m;
  logic          l_busy, l_done, l_err;
  logic [1023:0] l_result;
  logic [1:0]    l_cnt;

  int checks;
  int errors;

  barrett_final_sub_ctrl #(.N(8), .W(4), .MAX_SUB(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .r_in(s_r), .m_in(s_m),
    .busy(s_busy), .done(s_done), .result(s_result), .sub_count(s_cnt), .err(s_err)
  );

  barrett_final_sub_ctrl dut_l (
    .clk(clk), .rst_n(rst_n), .start(l_start), .r_in(l_r), .m_in(l_m),
    .busy(l_busy), .done(l_done), .result(l_result), .sub_count(l_cnt), .err(l_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: subtract m while r >= m, at most two times.
  task automatic model_small(input int r, input int m, output int res, output int cnt, output bit e);
    int rr;
    rr = r;
    cnt = 0;
    while (rr >= m && cnt < 2) begin
      rr = rr - m;
      cnt++;
    end
    e = (rr >= m);
    res = rr % 256;
  endtask

  task automatic run_small(input int r, input int m, output int lat, output bit timed_out);
    @(negedge clk);
    s_start = 1'b1;
    s_r = 10'(r);
    s_m = 8'(m);
    @(negedge clk);
    s_start = 1'b0;
    s_r = '0;
    s_m = '0;
    lat = 0;
    timed_out = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (s_done) begin
        lat = j;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s_start = 1'b0; s_r = '0; s_m = '0;
    l_start = 1'b0; l_r = '0; l_m = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_busy, s_done, s_err, s_cnt, s_result} !== 13'd0) begin
      errors++;
      $display("FAIL reset_small: got busy=%b done=%b err=%b cnt=%0d result=%0d, expected all 0",
               s_busy, s_done, s_err, s_cnt, s_result);
    end
    checks++;
    if (l_busy !== 1'b0 || l_done !== 1'b0 || l_err !== 1'b0 || l_cnt !== 2'd0 || l_result !== '0) begin
      errors++;
      $display("FAIL reset_large: got busy=%b done=%b err=%b cnt=%0d, expected all 0", l_busy, l_done, l_err, l_cnt);
    end
  endtask

  task automatic test_directed;
    int tr[7] = '{500, 150, 400, 200, 700, 5, 0};
    int tm[7] = '{200, 200, 200, 200, 200, 0, 37};
    int lat, exp_res, exp_cnt;
    bit to, exp_err;
    for (int i = 0; i < 7; i++) begin
      model_small(tr[i], tm[i], exp_res, exp_cnt, exp_err);
      run_small(tr[i], tm[i], lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: done never seen, expected within %0d cycles", i, (exp_cnt + 1) * 3);
        continue;
      end
      if (s_result !== 8'(exp_res)) begin
        errors++;
        $display("FAIL directed_result r=%0d m=%0d: got %0d, expected %0d", tr[i], tm[i], s_result, exp_res);
      end
      checks++;
      if (s_cnt !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL directed_count r=%0d m=%0d: got %0d, expected %0d", tr[i], tm[i], s_cnt, exp_cnt);
      end
      checks++;
      if (s_err !== exp_err) begin
        errors++;
        $display("FAIL directed_err r=%0d m=%0d: got %b, expected %b", tr[i], tm[i], s_err, exp_err);
      end
      checks++;
      if (lat != (exp_cnt + 1) * 3) begin
        errors++;
        $display("FAIL directed_latency r=%0d m=%0d: got %0d, expected %0d", tr[i], tm[i], lat, (exp_cnt + 1) * 3);
      end
      checks++;
      if (s_busy !== 1'b1) begin
        errors++;
        $display("FAIL directed_busy_in_done: got %b, expected 1", s_busy);
      end
      @(negedge clk);
      checks++;
      if (s_done !== 1'b0 || s_busy !== 1'b0 || s_result !== 8'(exp_res) || s_cnt !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL directed_after_done: got done=%b busy=%b result=%0d cnt=%0d, expected 0 0 %0d %0d",
                 s_done, s_busy, s_result, s_cnt, exp_res, exp_cnt);
      end
    end
  endtask

  task automatic test_start_ignored;
    bit to;
    @(negedge clk);
    s_start = 1'b1; s_r = 10'd500; s_m = 8'd200;
    @(negedge clk);
    s_start = 1'b0; s_r = '0; s_m = '0;
    repeat (2) @(negedge clk);
    s_start = 1'b1; s_r = 10'd150; s_m = 8'd100;
    @(negedge clk);
    s_start = 1'b0; s_r = '0; s_m = '0;
    to = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (s_done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (to || s_result !== 8'd100 || s_cnt !== 2'd2 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: timeout=%b result=%0d cnt=%0d err=%b, expected result=100 cnt=2 err=0",
               to, s_result, s_cnt, s_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pass;
    @(negedge clk);
    s_start = 1'b1; s_r = 10'd700; s_m = 8'd200;
    @(negedge clk);
    s_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_busy, s_done, s_err, s_cnt, s_result} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_pass: got busy=%b done=%b err=%b cnt=%0d result=%0d, expected all 0",
               s_busy, s_done, s_err, s_cnt, s_result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: got busy=%b done=%b, expected 0 0", s_busy, s_done);
    end
  endtask

  task automatic test_after_reset;
    int lat;
    bit to;
    run_small(250, 120, lat, to);
    checks++;
    if (to || s_result !== 8'd10 || s_cnt !== 2'd2 || s_err !== 1'b0 || lat != 9) begin
      errors++;
      $display("FAIL after_reset: timeout=%b result=%0d cnt=%0d err=%b lat=%0d, expected 10 2 0 9",
               to, s_result, s_cnt, s_err, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random_large;
    logic [1025:0] rem, rr, mm;
    logic [1023:0] m;
    int q, exp_cnt;
    bit to;
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 32; w++) begin
        m[w*32 +: 32] = $urandom;
        rem[w*32 +: 32] = $urandom;
      end
      rem[1025:1024] = 2'b00;
      if (it[0]) m = m >> $urandom_range(0, 900);
      if (m == '0) m = 1024'd1;
      mm = {2'b00, m};
      rem = rem % mm;
      q = $urandom_range(0, 2);
      rr = rem + mm * 1026'(q);
      @(negedge clk);
      l_start = 1'b1; l_r = rr; l_m = m;
      @(negedge clk);
      l_start = 1'b0; l_r = '0; l_m = '0;
      // Reference: repeated subtraction on the full-width value
      exp_cnt = 0;
      while (rr >= mm && exp_cnt < 2) begin
        rr = rr - mm;
        exp_cnt++;
      end
      to = 1'b1;
      for (int j = 0; j < 200; j++) begin
        @(negedge clk);
        if (l_done) begin
          to = 1'b0;
          break;
        end
      end
      checks++;
      if (to || l_result !== rr[1023:0] || l_cnt !== 2'(exp_cnt) || l_err !== 1'b0) begin
        errors++;
        $display("FAIL random_large[%0d]: timeout=%b cnt=%0d err=%b result_ok=%b, expected cnt=%0d err=0",
                 it, to, l_cnt, l_err, (l_result === rr[1023:0]), exp_cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_pass();
    test_after_reset();
    test_random_large();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/barrett_final_sub_ctrl.md
Name: barrett_final_sub_ctrl

Overview:
- Sequences the final correction step of Barrett reduction: given the estimate r < 3m, repeatedly subtracts m while r >= m, producing r mod m.
- Time-multiplexes one W-bit carry/subtract slice over the (N+2)-bit operand, K chunks per pass, so a 1024-bit result does not need a full-width carry chain.
- Sits between the Barrett quotient/remainder stage and the result register of the modular multiplier.

Parameters:
- N, 1024, modulus width in bits.
- W, 64, chunk width processed per cycle.
- MAX_SUB, 2, maximum committed subtractions before an error is declared.
- Derived, not overridable: K = ceil((N+2)/W), the number of chunks. Internal registers are K*W bits wide, zero-extended.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a reduction; sampled only in IDLE.
- r_in  in  N+2  Barrett remainder estimate.
- m_in  in  N  modulus.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse; result, sub_count and err are valid in that cycle.
- result  out  N  low N bits of the final remainder.
- sub_count  out  2  number of committed subtractions.
- err  out  1  set when r >= m still holds after MAX_SUB subtractions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err=0; result=0; sub_count=0; all internal registers cleared. Reset mid-pass aborts the operation; nothing partial is committed.
- FSM states: IDLE, PASS, DONE.
- IDLE, start=1 at edge t0:
  - latch R<=r_in and M<=m_in (both zero-extended);
  - idx<=0, carry<=1, cnt<=0, err<=0;
  - go to PASS.
  - start while busy is ignored; r_in/m_in are don't-care after t0.
- PASS, each edge processes chunk idx:
  - {c, D[idx]} = R[idx] + ~M[idx] + carry (W-bit chunks);
  - carry<=c; idx<=idx+1.
  - This is a borrow-free compare and subtract: final carry=1 iff R >= M.
- End-of-pass decision, at the edge that processes chunk K-1, using the final carry:
  - carry=1 and cnt<MAX_SUB: R<=D (D[K-1] uses this edge's value), cnt<=cnt+1, idx<=0, carry<=1, stay in PASS.
  - carry=1 and cnt==MAX_SUB: err<=1, R unchanged, go to DONE.
  - carry=0: R unchanged, go to DONE.
- DONE: done=1 for exactly one cycle.
  - result = R[N-1:0]; sub_count = cnt.
  - Next edge returns to IDLE.
  - result, sub_count and err hold until the next accepted start.
- Latency: for s committed subtractions, done is high in the cycle after edge t0+(s+1)*K. Worst case is (MAX_SUB+1)*K+1 cycles from start.
- busy=1 in PASS and DONE, 0 in IDLE.
- Boundary cases:
  - m=0: every pass carries, so err=1 and sub_count=MAX_SUB; result = r_in low N bits.
  - r=m exactly: one commit, result 0.
  - Arithmetic is modulo 2^(K*W); the padding chunk bits of M are 0.

Test Plan (N=8, W=4, K=3, MAX_SUB=2 unless stated):
- r_in=500, m_in=200 -> passes give 300, then 100; 100<200 -> result=100, sub_count=2, err=0; done in the cycle after edge t0+9.
- r_in=150, m_in=200 -> result=150, sub_count=0, err=0; done in the cycle after edge t0+3.
- r_in=400, m_in=200 -> 200, then 0 -> result=0, sub_count=2, err=0; r_in=200, m_in=200 -> result=0, sub_count=1.
- r_in=700, m_in=200 -> 500, then 300; third pass still carries -> err=1, result=300 mod 256=44, sub_count=2.
- m_in=0, r_in=5 -> err=1, result=5, sub_count=2.
- Control cases:
  - start pulsed during PASS -> ignored; result matches the first operands.
  - rst_n low mid-PASS -> all outputs 0 immediately, state=IDLE.
  - A new start after reset completes normally.
  - Random default-parameter (N=1024, W=64) run checks result = r_in mod m_in against a reference model, with r_in < 3*m_in.
